// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_pkg
//  Purpose  : Shared definitions for the boot-time program loader: default
//             sizing, frame start marker and the frame-parser state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    localparam int unsigned     c_ADDR_W    = 4;
    localparam int unsigned     c_DATA_W    = 8;
    localparam logic [7:0]      c_SYNC_BYTE = 8'hA5;

    // Number of instruction words addressable with the given address width.
    function automatic int unsigned f_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int unsigned     c_DEPTH     = f_depth(c_ADDR_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Receives a framed byte stream (SYNC, COUNT, payload, CSUM) and
//             writes the payload to consecutive instruction-memory addresses
//             starting at 0. Holds the processor in reset until a frame with
//             a correct checksum has been loaded.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_data/in_ready - byte stream, consumed on
//                                         in_valid && in_ready at posedge clk
//             mem_we/mem_addr/mem_wdata - instruction memory write port
//             cpu_hold                  - 1 keeps the processor in reset
//             done / error              - status of the last frame
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned        ADDR_W    = c_ADDR_W,
    parameter int unsigned        DATA_W    = c_DATA_W,
    parameter logic [DATA_W-1:0]  SYNC_BYTE = c_SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error
);

    localparam int unsigned     c_DEPTH_P  = f_depth(ADDR_W);
    localparam logic [31:0]     c_DEPTH_32 = 32'(c_DEPTH_P);
    localparam logic [ADDR_W:0] c_ADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;

    // One bit wider than mem_addr so a full DEPTH-word frame can be counted
    // without wrapping before the checksum byte arrives.
    logic [ADDR_W:0]     r_addr;
    logic [ADDR_W:0]     w_addr_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic [DATA_W-1:0]   r_sum;
    logic [DATA_W-1:0]   w_sum_nxt;

    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_error;

    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_waddr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;

    logic                w_acc;
    logic                w_is_sync;
    logic [31:0]         w_n_ext;
    logic                w_n_ok;
    logic [ADDR_W:0]     w_addr_inc;

    assign w_acc      = in_valid && r_in_ready;
    assign w_is_sync  = (in_data == SYNC_BYTE);
    assign w_n_ext    = 32'(in_data);
    assign w_n_ok     = (w_n_ext != 32'd0) && (w_n_ext <= c_DEPTH_32);
    assign w_addr_inc = r_addr + c_ADDR_ONE;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = r_sum;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;

        if (w_acc) begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (w_is_sync) begin
                        w_state_nxt = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (w_n_ok) begin
                        w_state_nxt = ST_DATA;
                        w_addr_nxt  = '0;
                        w_sum_nxt   = '0;
                        w_cnt_nxt   = w_n_ext[ADDR_W:0];
                    end else begin
                        w_state_nxt = ST_ERROR;
                    end
                end
                ST_DATA: begin
                    // A sync byte here is ordinary payload.
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_addr[ADDR_W-1:0];
                    w_wdata_nxt = in_data;
                    w_sum_nxt   = r_sum + in_data;
                    w_addr_nxt  = w_addr_inc;
                    if (w_addr_inc == r_cnt) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    w_state_nxt = (in_data == r_sum) ? ST_DONE : ST_ERROR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers. Status flags are derived from the next
    // state so they change in the cycle right after the deciding byte.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sum       <= w_sum_nxt;
            r_in_ready  <= 1'b1;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_waddr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_cpu_hold  <= (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
            r_error     <= (w_state_nxt == ST_ERROR);
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader. Directed frames from a
//             table, hand-written reset/reload sequences and randomized frame
//             streams compared against a stream-parsing reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          total = 0;
    int          bad   = 0;

    logic [11:0] act_wr[$];
    logic [11:0] exp_wr[$];
    logic [7:0]  hist[$];
    logic        m_done, m_err, m_hold;

    typedef struct {
        logic [159:0] bytes;   // right-aligned, first byte most significant
        int           len;
        logic         e_done;
        logic         e_err;
        logic         e_hold;
        int           e_nwr;
    } vec_t;

    vec_t tbl[6];

    program_loader #(
        .ADDR_W    (4),
        .DATA_W    (8),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Capture every memory write one step after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) act_wr.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        hist.delete();
        act_wr.delete();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        hist.push_back(b);
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: parse the whole accepted stream since reset as a
    // sequence of frames and derive the writes and the final status.
    function automatic void run_model();
        int         i;
        int         n;
        int         st;      // 0 idle, 1 loaded, 2 rejected, 3 inside a frame
        logic [7:0] sum;
        logic [3:0] ka;
        exp_wr.delete();
        st = 0;
        i  = 0;
        while (i < hist.size()) begin
            if (hist[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            st = 3;
            if (i >= hist.size()) break;
            n = int'(hist[i]);
            i++;
            if (n == 0 || n > 16) begin
                st = 2;
                continue;
            end
            sum = 8'h00;
            for (int k = 0; k < n && i < hist.size(); k++) begin
                ka = 4'(k);
                exp_wr.push_back({ka, hist[i]});
                sum = sum + hist[i];
                i++;
            end
            if (i >= hist.size()) break;
            st = (hist[i] == sum) ? 1 : 2;
            i++;
        end
        m_done = (st == 1);
        m_err  = (st == 2);
        m_hold = (st != 1);
    endfunction

    task automatic cmp_model(input string name);
        run_model();
        chk({name, ":nwr"}, act_wr.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < act_wr.size(); k++)
            chk({name, ":wr"}, {20'h0, act_wr[k]}, {20'h0, exp_wr[k]});
        chk({name, ":done"},  {31'h0, done},     {31'h0, m_done});
        chk({name, ":error"}, {31'h0, error},    {31'h0, m_err});
        chk({name, ":hold"},  {31'h0, cpu_hold}, {31'h0, m_hold});
    endtask

    initial begin
        tbl[0] = '{160'hA510ABDE3CD6BCCDAEA1B2D4E5F6AFEF678861, 19, 1'b1, 1'b0, 1'b0, 16};
        tbl[1] = '{160'hA502112234,                            5, 1'b0, 1'b1, 1'b1, 2};
        tbl[2] = '{160'hA500,                                  2, 1'b0, 1'b1, 1'b1, 0};
        tbl[3] = '{160'hA511A5017F7F,                          6, 1'b1, 1'b0, 1'b0, 1};
        tbl[4] = '{160'h00FF5AA501C3C3,                        7, 1'b1, 1'b0, 1'b0, 1};
        tbl[5] = '{160'hA501A5A5,                              4, 1'b1, 1'b0, 1'b0, 1};

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #2;
        chk("rst:in_ready",  {31'h0, in_ready},  32'd0);
        chk("rst:mem_we",    {31'h0, mem_we},    32'd0);
        chk("rst:mem_addr",  {28'h0, mem_addr},  32'd0);
        chk("rst:mem_wdata", {24'h0, mem_wdata}, 32'd0);
        chk("rst:cpu_hold",  {31'h0, cpu_hold},  32'd1);
        chk("rst:done",      {31'h0, done},      32'd0);
        chk("rst:error",     {31'h0, error},     32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("post_rst:in_ready", {31'h0, in_ready}, 32'd1);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int j = 0; j < tbl[v].len; j++)
                send(tbl[v].bytes[8*(tbl[v].len-1-j) +: 8], $urandom_range(0, 3));
            chk($sformatf("tbl%0d:nwr", v),   act_wr.size(),         tbl[v].e_nwr);
            chk($sformatf("tbl%0d:done", v),  {31'h0, done},     {31'h0, tbl[v].e_done});
            chk($sformatf("tbl%0d:error", v), {31'h0, error},    {31'h0, tbl[v].e_err});
            chk($sformatf("tbl%0d:hold", v),  {31'h0, cpu_hold}, {31'h0, tbl[v].e_hold});
            cmp_model($sformatf("tbl%0d", v));
        end

        // ---------------- reset in the middle of the payload ----------------
        do_reset();
        send(8'hA5, 0);
        send(8'h10, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        chk("mid:we_before_rst", {31'h0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid:we_async",    {31'h0, mem_we},    32'd0);
        chk("mid:ready_async", {31'h0, in_ready},  32'd0);
        chk("mid:addr_async",  {28'h0, mem_addr},  32'd0);
        chk("mid:wdata_async", {24'h0, mem_wdata}, 32'd0);
        chk("mid:hold_async",  {31'h0, cpu_hold},  32'd1);
        in_valid = 1'b1;
        in_data  = 8'h44;
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #2;
        chk("mid:no_more_writes", act_wr.size(), 32'd3);
        hist.delete();
        act_wr.delete();
        for (int j = 0; j < tbl[0].len; j++)
            send(tbl[0].bytes[8*(tbl[0].len-1-j) +: 8], 0);
        cmp_model("mid:reload");

        // ---------------- reload after DONE ----------------
        send(8'hA5, 0);
        chk("reload:hold_after_sync", {31'h0, cpu_hold}, 32'd1);
        chk("reload:done_after_sync", {31'h0, done},     32'd0);
        send(8'h01, 0);
        send(8'h67, 0);
        chk("reload:we",    {31'h0, mem_we},    32'd1);
        chk("reload:addr",  {28'h0, mem_addr},  32'd0);
        chk("reload:wdata", {24'h0, mem_wdata}, 32'h67);
        send(8'h67, 0);
        chk("reload:done",  {31'h0, done},     32'd1);
        chk("reload:hold",  {31'h0, cpu_hold}, 32'd0);
        chk("reload:error", {31'h0, error},    32'd0);
        cmp_model("reload");

        // ---------------- randomized frame stream ----------------
        do_reset();
        for (int f = 0; f < 40; f++) begin
            int         nnoise;
            int         n;
            logic [7:0] b;
            logic [7:0] sum;
            nnoise = $urandom_range(0, 2);
            for (int k = 0; k < nnoise; k++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                send(b, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
            else
                n = $urandom_range(1, 16);
            send(8'hA5, $urandom_range(0, 3));
            send(8'(n), $urandom_range(0, 3));
            if (n >= 1 && n <= 16) begin
                sum = 8'h00;
                for (int k = 0; k < n; k++) begin
                    b   = 8'($urandom);
                    sum = sum + b;
                    send(b, $urandom_range(0, 3));
                end
                if ($urandom_range(0, 3) == 0)
                    sum = sum ^ 8'($urandom_range(1, 255));
                send(sum, $urandom_range(0, 3));
            end
            cmp_model($sformatf("rand%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
